fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Owns the architectural PC and sequences instruction fetch between the next-PC logic, instruction memory and the decode stage. Issues one outstanding instruction-memory request at a time with a hold-until-ack handshake and applies redirects: branch, jump, jr, exception and eret targets, already prioritised upstream. Outstanding responses are discarded on redirect. Fetched words are buffered in a two-entry output/skid pair so decode stalls never lose a memory response.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect  in  1  control transfer resolved this cycle; overrides sequential fetch.
- redirect_pc  in  32  target for redirect, the selected next PC.
- stall  in  1  decode cannot accept this cycle.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  request address, word aligned.
- imem_ack  in  1  response valid this cycle; may coincide with the first imem_req cycle.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- if_valid  out  1  if_inst/if_pc hold a fetched instruction.
- if_inst  out  32  fetched instruction.
- if_pc  out  32  address of if_inst.
- if_adel  out  1  fetch address error (see Configuration).

## Operation
- State register with three states: IDLE (no request), BUSY (request outstanding, data wanted), KILL (request outstanding, data to be dropped).
- Registers:
  - pc: next address to fetch.
  - imem_addr: latched per request.
  - out: valid, inst, pc.
  - skid: valid, inst, pc.
- Issue rule:
  - A new request may start only when skid will be empty after this edge.
  - Starting a request sets imem_addr <= pc and pc <= pc + 4, with 32-bit wrap (32'hFFFF_FFFC + 4 = 0).
- Request rules:
  - imem_req and imem_addr are register outputs.
  - Once imem_req rises, both stay constant until the cycle imem_ack=1.
- IDLE: goes to BUSY when the issue rule holds.
- BUSY with ack and no redirect:
  - If out is empty or being consumed (stall=0), data goes to out; otherwise it goes to skid.
  - Next state is BUSY with the next request if the issue rule holds, else IDLE.
- Consume: when if_valid & ~stall, skid (if valid) moves into out; otherwise out empties.
- Redirect has top priority, and stall is ignored in that cycle:
  - out and skid are invalidated; if_valid is 0 the next cycle.
  - pc <= redirect_pc.
  - If BUSY without ack: go to KILL; imem_req stays high at the old address.
  - If BUSY with ack, or IDLE: data is dropped; next state is BUSY with imem_addr = redirect_pc, pc = redirect_pc + 4.
  - If KILL without ack: stay in KILL; pc is overwritten again, so the last redirect wins.
  - If KILL with ack: data is dropped; next state is BUSY at redirect_pc.
- KILL with ack and no redirect: data is dropped; next state is BUSY if the issue rule holds, else IDLE.
- Reset mid-request: the outstanding request is abandoned. The memory side must tolerate imem_req falling before ack.

## Timing
- Reset values:
  - imem_req 0, imem_addr RESET_PC, pc RESET_PC.
  - if_valid 0, if_inst 0, if_pc 0, if_adel 0, state IDLE.
- First imem_req is high in the first cycle after the first clock edge with rst=0.
- Latency: ack at cycle t gives if_valid at t+1.
- Throughput: one instruction per cycle with zero-wait memory (ack in the same cycle as req).
- Redirect in cycle t: if_valid=0 at t+1. With zero-wait memory, the target instruction is valid at t+2.
- Skid full with stall held: imem_req stays low; no response is ever lost.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 issues no request.
  - Next cycle: if_valid=1, if_adel=1, if_pc=redirect_pc, if_inst=0.
  - This output is held, and no fetching occurs, until the next redirect; stall has no effect on it.
- Undefined:
  - redirect_pc[1:0] is ignored (treated as 00).
  - if_adel is tied to 0.

## Test plan
- Reset, zero-wait memory, stall=0: imem_addr sequence 0, 4, 8, 12 on consecutive cycles; if_pc one cycle behind; if_inst equals the memory contents.
- Memory with 3-cycle ack delay: imem_req/imem_addr stay stable until ack; one instruction per 3 cycles; no duplicate or missing PCs.
- stall held high for 5 cycles during streaming:
  - out and skid both fill; imem_req drops.
  - After stall release, PCs continue in order with none lost.
- Redirect to 32'h0000_0100 while a 3-cycle request to 32'h0000_0010 is outstanding:
  - imem_addr stays at 32'h0000_0010 until ack, and that data is dropped.
  - Next request is 32'h0000_0100; if_pc=32'h0000_0010 never appears.
- Redirect coinciding with ack and with stall=1: data is dropped; if_valid=0 the next cycle; the next request is redirect_pc.
- With FETCH_ALIGN_CHECK_EN, redirect to 32'h0000_0102:
  - if_adel=1, if_pc=32'h0000_0102, imem_req=0.
  - A following redirect to 32'h0000_0200 resumes fetching with if_adel=0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Instruction-memory request/response bundle between the fetch sequencer
//   (master) and the instruction memory (slave).
//   Signals:
//     imem_req    master->slave  request strobe, held until imem_ack
//     imem_addr   master->slave  word-aligned request address
//     imem_ack    slave->master  response valid (may be the first req cycle)
//     imem_rdata  slave->master  instruction word, valid with imem_ack
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the architectural PC and sequences instruction fetch: one outstanding
//   instruction-memory request at a time (held until ack), redirects from the
//   next-PC logic, and a two-entry output/skid buffer toward decode so that a
//   decode stall never loses a memory response.
//   Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect targets
//   raise if_adel instead of fetching).
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     redirect      control transfer this cycle (overrides sequential fetch)
//     redirect_pc   redirect target
//     stall         decode cannot accept this cycle
//     imem          instruction-memory bundle (master side)
//     if_valid      if_inst/if_pc hold a fetched instruction
//     if_inst       fetched instruction word
//     if_pc         address of if_inst
//     if_adel       fetch address error (0 unless FETCH_ALIGN_CHECK_EN)
//
//   state | meaning
//   ------+-------------------------------------------------
//   IDLE  | no request outstanding
//   BUSY  | request outstanding, response will be kept
//   KILL  | request outstanding, response will be dropped
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     stall,
  fetch_sequencer_if.master        imem,
  output logic                     if_valid,
  output logic [31:0]              if_inst,
  output logic [31:0]              if_pc,
  output logic                     if_adel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    KILL = 2'd2
  } state_t;

  state_t      state, state_n;

  logic [31:0] pc_q, pc_n;
  logic [31:0] addr_q, addr_n;
  logic        req_q, req_n;
  logic        out_v, out_v_n;
  logic [31:0] out_inst, out_inst_n;
  logic [31:0] out_pc, out_pc_n;
  logic        skid_v, skid_v_n;
  logic [31:0] skid_inst, skid_inst_n;
  logic [31:0] skid_pc, skid_pc_n;
  logic        err_q, err_n;

  logic        misalign;
  logic [31:0] rpc;
  logic        ack_data;
  logic        consume;
  logic        issue_ok;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign = redirect & (redirect_pc[1:0] != 2'b00);
  assign rpc      = redirect_pc;
`else
  logic unused_lsbs;
  assign unused_lsbs = ^redirect_pc[1:0];
  assign misalign    = 1'b0;
  assign rpc         = {redirect_pc[31:2], 2'b00};
`endif

  // Only a BUSY response is kept; a KILL response is swallowed.
  assign ack_data = (state == BUSY) & imem.imem_ack;
  // An address-error entry is held until the next redirect, so it is never consumed.
  assign consume  = out_v & ~stall & ~err_q;

  always_comb begin
    state_n     = state;
    pc_n        = pc_q;
    addr_n      = addr_q;
    req_n       = req_q;
    out_v_n     = out_v;
    out_inst_n  = out_inst;
    out_pc_n    = out_pc;
    skid_v_n    = skid_v;
    skid_inst_n = skid_inst;
    skid_pc_n   = skid_pc;
    err_n       = err_q;
    issue_ok    = 1'b0;

    if (redirect) begin
      out_v_n  = 1'b0;
      skid_v_n = 1'b0;
      pc_n     = rpc;
      err_n    = misalign;
      if (misalign) begin
        out_v_n    = 1'b1;
        out_inst_n = 32'h0000_0000;
        out_pc_n   = redirect_pc;
      end
      if ((state != IDLE) && !imem.imem_ack) begin
        // Old request must complete at its original address before retargeting.
        state_n = KILL;
        req_n   = 1'b1;
      end else if (misalign) begin
        state_n = IDLE;
        req_n   = 1'b0;
      end else begin
        state_n = BUSY;
        req_n   = 1'b1;
        addr_n  = rpc;
        pc_n    = rpc + 32'd4;
      end
    end else begin
      // A request only starts with skid empty, so skid is always empty on ack.
      if (ack_data && (!out_v || !stall)) begin
        out_v_n    = 1'b1;
        out_inst_n = imem.imem_rdata;
        out_pc_n   = addr_q;
      end else if (ack_data) begin
        skid_v_n    = 1'b1;
        skid_inst_n = imem.imem_rdata;
        skid_pc_n   = addr_q;
      end else if (consume) begin
        out_v_n    = skid_v;
        out_inst_n = skid_inst;
        out_pc_n   = skid_pc;
        skid_v_n   = 1'b0;
      end

      issue_ok = !skid_v_n && !err_q;

      unique case (state)
        IDLE: begin
          if (issue_ok) begin
            state_n = BUSY;
            req_n   = 1'b1;
            addr_n  = pc_q;
            pc_n    = pc_q + 32'd4;
          end
        end
        BUSY, KILL: begin
          if (imem.imem_ack) begin
            if (issue_ok) begin
              state_n = BUSY;
              req_n   = 1'b1;
              addr_n  = pc_q;
              pc_n    = pc_q + 32'd4;
            end else begin
              state_n = IDLE;
              req_n   = 1'b0;
            end
          end
        end
        default: begin
          state_n = IDLE;
          req_n   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      req_q     <= 1'b0;
      out_v     <= 1'b0;
      out_inst  <= 32'h0000_0000;
      out_pc    <= 32'h0000_0000;
      skid_v    <= 1'b0;
      skid_inst <= 32'h0000_0000;
      skid_pc   <= 32'h0000_0000;
      err_q     <= 1'b0;
    end else begin
      pc_q      <= pc_n;
      addr_q    <= addr_n;
      req_q     <= req_n;
      out_v     <= out_v_n;
      out_inst  <= out_inst_n;
      out_pc    <= out_pc_n;
      skid_v    <= skid_v_n;
      skid_inst <= skid_inst_n;
      skid_pc   <= skid_pc_n;
      err_q     <= err_n;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign if_valid       = out_v;
  assign if_inst        = out_inst;
  assign if_pc          = out_pc;
  assign if_adel        = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Scoreboard bench: each test pushes the expected (pc, inst) stream into a
//   queue; a negedge monitor pops and compares every instruction decode takes.
//   A memory model answers requests after a programmable number of wait cycles
//   and checks that the request address stays stable until ack.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_adel;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .imem        (bus),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .if_adel     (if_adel)
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   lat      = 0;
  int   popped   = 0;
  int   pop_cyc[64];
  logic mon_en   = 1'b1;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] minst(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc   = base + 32'(4 * i);
      e.inst = minst(base + 32'(4 * i));
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_pops(input int k, input int budget);
    int n;
    n = 0;
    while (popped < k && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (popped < k) begin
      checks++;
      failures++;
      $display("FAIL timeout_pops actual=%0d required=%0d", popped, k);
    end
  endtask

  task automatic start_test(input int latency);
    rst      = 1'b1;
    redirect = 1'b0;
    stall    = 1'b0;
    mon_en   = 1'b1;
    lat      = latency;
    exp_q.delete();
    popped   = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req",  {31'd0, bus.imem_req}, 32'd0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0000_0000);
    chk("rst_if_valid",  {31'd0, if_valid}, 32'd0);
    chk("rst_if_inst",   if_inst, 32'd0);
    chk("rst_if_pc",     if_pc, 32'd0);
    chk("rst_if_adel",   {31'd0, if_adel}, 32'd0);
  endtask

  // Memory model: ack after lat wait cycles, address must hold until ack.
  initial begin
    int          cnt;
    logic        in_req;
    logic [31:0] held;
    cnt = 0;
    in_req = 1'b0;
    held = 32'd0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (rst || !bus.imem_req) begin
        if (in_req && !rst) begin
          checks++;
          failures++;
          $display("FAIL req_dropped_before_ack addr=%h", held);
        end
        in_req = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
      end else begin
        if (!in_req) begin
          in_req = 1'b1;
          cnt    = 0;
          held   = bus.imem_addr;
        end else begin
          cnt++;
          chk("imem_addr_stable", bus.imem_addr, held);
        end
        bus.imem_ack   = (cnt >= lat);
        bus.imem_rdata = (cnt >= lat) ? minst(bus.imem_addr) : 32'hDEAD_BEEF;
        if (cnt >= lat) in_req = 1'b0;
      end
    end
  end

  // Monitor: an instruction is taken by decode when valid, not stalled, no redirect.
  initial forever begin
    @(negedge clk);
    if (!rst && mon_en && !redirect && if_valid && !stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow actual_pc=%h required=none", if_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("if_pc",   if_pc, e.pc);
        chk("if_inst", if_inst, e.inst);
        chk("if_adel", {31'd0, if_adel}, 32'd0);
        if (popped < 64) pop_cyc[popped] = cyc;
        popped++;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    stall = 1'b0;

    // Zero-wait streaming: address sequence and one instruction per cycle.
    start_test(0);
    push_seq(32'h0, 16);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("stream_req",  {31'd0, bus.imem_req}, 32'd1);
      chk("stream_addr", bus.imem_addr, 32'(4 * i));
    end
    wait_pops(8, 40);
    chk("zero_wait_spacing", 32'(pop_cyc[3] - pop_cyc[2]), 32'd1);

    // Three-cycle memory.
    start_test(2);
    push_seq(32'h0, 10);
    rst = 1'b0;
    wait_pops(6, 60);
    chk("wait3_spacing_a", 32'(pop_cyc[1] - pop_cyc[0]), 32'd3);
    chk("wait3_spacing_b", 32'(pop_cyc[5] - pop_cyc[4]), 32'd3);

    // Stall for 5 cycles during streaming fills out and skid.
    start_test(0);
    push_seq(32'h0, 20);
    rst = 1'b0;
    wait_pops(3, 40);
    stall = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("stall_req_low",  {31'd0, bus.imem_req}, 32'd0);
    chk("stall_if_valid", {31'd0, if_valid}, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    chk("stall_req_still_low", {31'd0, bus.imem_req}, 32'd0);
    stall = 1'b0;
    wait_pops(12, 40);

    // Redirect while a slow request to 0x10 is outstanding.
    start_test(2);
    push_seq(32'h0, 8);
    rst = 1'b0;
    n = 0;
    while (!(bus.imem_req && bus.imem_addr == 32'h10) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("kill_found_req10", {31'd0, bus.imem_req}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    exp_q.delete();
    push_seq(32'h100, 8);
    popped = 0;
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("kill_if_valid", {31'd0, if_valid}, 32'd0);
    chk("kill_req_held", {31'd0, bus.imem_req}, 32'd1);
    chk("kill_addr_held", bus.imem_addr, 32'h10);
    n = 0;
    while (bus.imem_addr == 32'h10 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("kill_next_addr", bus.imem_addr, 32'h100);
    wait_pops(3, 40);

    // Redirect coinciding with ack and stall.
    start_test(0);
    push_seq(32'h0, 20);
    rst = 1'b0;
    wait_pops(4, 40);
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    exp_q.delete();
    push_seq(32'h200, 8);
    popped = 0;
    @(posedge clk); #1;
    redirect = 1'b0;
    stall    = 1'b0;
    chk("redir_ack_if_valid", {31'd0, if_valid}, 32'd0);
    chk("redir_ack_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("redir_ack_addr", bus.imem_addr, 32'h200);
    @(posedge clk); #1;
    chk("redir_target_valid", {31'd0, if_valid}, 32'd1);
    chk("redir_target_pc", if_pc, 32'h200);
    wait_pops(4, 40);

    // Misaligned redirect target.
    start_test(0);
    push_seq(32'h0, 20);
    rst = 1'b0;
    wait_pops(2, 40);
`ifdef FETCH_ALIGN_CHECK_EN
    mon_en      = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    exp_q.delete();
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("adel_valid", {31'd0, if_valid}, 32'd1);
    chk("adel_flag",  {31'd0, if_adel}, 32'd1);
    chk("adel_pc",    if_pc, 32'h102);
    chk("adel_inst",  if_inst, 32'd0);
    stall = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    stall = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("adel_req_low",   {31'd0, bus.imem_req}, 32'd0);
    chk("adel_held",      {31'd0, if_adel}, 32'd1);
    chk("adel_held_pc",   if_pc, 32'h102);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    push_seq(32'h200, 8);
    popped = 0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("adel_cleared", {31'd0, if_adel}, 32'd0);
    chk("adel_resume_addr", bus.imem_addr, 32'h200);
    wait_pops(4, 40);
`else
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    exp_q.delete();
    push_seq(32'h100, 8);
    popped = 0;
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("lsb_ignored_addr", bus.imem_addr, 32'h100);
    chk("lsb_ignored_adel", {31'd0, if_adel}, 32'd0);
    chk("lsb_ignored_valid", {31'd0, if_valid}, 32'd0);
    wait_pops(4, 40);
`endif

    rst = 1'b1;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
